// File: rtl/pipelined_rca_pkg.sv
// Shared types and elaboration helpers for the pipelined ripple-carry adder.
package pipelined_rca_pkg;

    localparam int MIN_WIDTH  = 2;
    localparam int MIN_STAGES = 1;

    // Control bits that travel with each operation through the pipe.
    typedef struct packed {
        logic valid;
        logic sub;
    } ctrl_t;

    function automatic int seg_width(input int width, input int stages);
        return (stages > 0) ? width / stages : width;
    endfunction

    function automatic bit cfg_ok(input int width, input int stages);
        return (width >= MIN_WIDTH) && (stages >= MIN_STAGES) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/pipelined_rca_segment.sv
// One SEG-bit combinational ripple chain; also reports the carry into its MSB.
module rca_segment #(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a_i,
    input  logic [SEG-1:0] b_i,
    input  logic           cin_i,
    output logic [SEG-1:0] s_o,
    output logic           cout_o,
    output logic           cmsb_o
);

    logic carry;

    always_comb begin
        carry  = cin_i;
        s_o    = '0;
        cmsb_o = 1'b0;
        for (int i = 0; i < SEG; i++) begin
            if (i == SEG - 1) begin
                cmsb_o = carry;
            end
            s_o[i] = a_i[i] ^ b_i[i] ^ carry;
            carry  = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
        end
        cout_o = carry;
    end

endmodule

// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry adder/subtractor: one SEG-bit ripple segment per stage.
// Optional saturation on signed overflow is enabled with PIPELINED_RCA_SAT_EN.
module pipelined_rca
    import pipelined_rca_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SEG  = seg_width(WIDTH, STAGES);
    localparam int LAST = STAGES - 1;

    if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
        $error("pipelined_rca: WIDTH must be >= 2 and a multiple of STAGES");
    end

    // Register k holds the operation after segment k has been added: raw
    // operands (skew), completed low sum bits (deskew) and the carry out.
    ctrl_t [STAGES-1:0]            ctrl_q, ctrl_d;
    logic  [STAGES-1:0][WIDTH-1:0] a_q, a_d;
    logic  [STAGES-1:0][WIDTH-1:0] b_q, b_d;
    logic  [STAGES-1:0][WIDTH-1:0] s_q, s_d;
    logic  [STAGES-1:0]            c_q, c_d;
    logic  [STAGES-1:0]            cmsb_w;
    logic                          ovf_q, ovf_d;
    logic                          adv;

    assign adv       = !ctrl_q[LAST].valid || out_ready;
    assign in_ready  = adv;
    assign out_valid = ctrl_q[LAST].valid;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        ctrl_t            src_ctrl;
        logic [WIDTH-1:0] src_a;
        logic [WIDTH-1:0] src_b;
        logic [WIDTH-1:0] src_s;
        logic             src_c;
        logic [SEG-1:0]   seg_b;
        logic [SEG-1:0]   seg_s;
        logic             seg_co;
        logic [WIDTH-1:0] nxt_s;

        if (k == 0) begin : g_head
            assign src_ctrl = '{valid: in_valid, sub: sub};
            assign src_a    = a;
            assign src_b    = b;
            assign src_s    = '0;
            assign src_c    = sub ? 1'b1 : cin;
        end else begin : g_body
            assign src_ctrl = ctrl_q[k-1];
            assign src_a    = a_q[k-1];
            assign src_b    = b_q[k-1];
            assign src_s    = s_q[k-1];
            assign src_c    = c_q[k-1];
        end

        // B is inverted per segment from the travelling sub flag.
        assign seg_b = src_b[k*SEG +: SEG] ^ {SEG{src_ctrl.sub}};

        rca_segment #(
            .SEG (SEG)
        ) u_seg (
            .a_i    (src_a[k*SEG +: SEG]),
            .b_i    (seg_b),
            .cin_i  (src_c),
            .s_o    (seg_s),
            .cout_o (seg_co),
            .cmsb_o (cmsb_w[k])
        );

        always_comb begin
            nxt_s                = src_s;
            nxt_s[k*SEG +: SEG]  = seg_s;
        end

        assign ctrl_d[k] = src_ctrl;
        assign a_d[k]    = src_a;
        assign b_d[k]    = src_b;
        assign s_d[k]    = nxt_s;
        assign c_d[k]    = seg_co;
    end

    assign ovf_d = c_d[LAST] ^ cmsb_w[LAST];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_q <= '0;
            a_q    <= '0;
            b_q    <= '0;
            s_q    <= '0;
            c_q    <= '0;
            ovf_q  <= 1'b0;
        end else if (adv) begin
            ctrl_q <= ctrl_d;
            a_q    <= a_d;
            b_q    <= b_d;
            s_q    <= s_d;
            c_q    <= c_d;
            ovf_q  <= ovf_d;
        end
    end

    assign cout = c_q[LAST];
    assign ovf  = ovf_q;

`ifdef PIPELINED_RCA_SAT_EN
    localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG = ~SAT_POS;

    // Overflow pins the result towards the sign of A.
    always_comb begin
        sum = s_q[LAST];
        if (ovf_q) begin
            sum = a_q[LAST][WIDTH-1] ? SAT_NEG : SAT_POS;
        end
    end
`else
    assign sum = s_q[LAST];
`endif

    // Already-consumed operand bits and intermediate MSB carries have no reader.
    logic unused_bits;
    assign unused_bits = ^{a_q, b_q, cmsb_w, ctrl_q[LAST].sub};

endmodule

// File: tb/tb_pipelined_rca.sv
// Self-checking bench for pipelined_rca (WIDTH=16, STAGES=4).
module tb_pipelined_rca;

    localparam int W = 16;
    localparam int S = 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int checks   = 0;
    int failures = 0;
    int n_out    = 0;

    // Each entry is {ovf, cout, sum}.
    logic [W+1:0] exp_q[$];

    pipelined_rca #(
        .WIDTH  (W),
        .STAGES (S)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Arithmetic reference: signed overflow from operand and result signs.
    function automatic logic [W+1:0] model(input logic [W-1:0] xa, input logic [W-1:0] xb,
                                           input logic xcin, input logic xsub);
        logic [W-1:0] bp;
        logic [W:0]   full;
        logic [W-1:0] res;
        logic         v;
        bp   = xsub ? ~xb : xb;
        full = {1'b0, xa} + {1'b0, bp} + {{W{1'b0}}, (xsub | xcin)};
        v    = (xa[W-1] == bp[W-1]) && (full[W-1] != xa[W-1]);
        res  = full[W-1:0];
`ifdef PIPELINED_RCA_SAT_EN
        if (v) res = xa[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
        return {v, full[W], res};
    endfunction

    // Scoreboard: capture accepted operands, compare every presented result.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", {ovf, cout, sum}, '1);
                end else begin
                    check("out_result", {ovf, cout, sum}, exp_q[0]);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        n_out++;
                    end
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                          input logic xcin, input logic xsub);
        a   = xa;
        b   = xb;
        cin = xcin;
        sub = xsub;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            step();
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    // One op into an idle pipe; pins latency and the literal result.
    task automatic single_op(input string name, input logic [W-1:0] xa, input logic [W-1:0] xb,
                             input logic xcin, input logic xsub,
                             input logic [W-1:0] e_sum, input logic e_cout, input logic e_ovf);
        int lat;
        out_ready = 1'b1;
        set_op(xa, xb, xcin, xsub);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        check({name, "_latency"}, lat, S);
        check({name, "_sum"}, sum, e_sum);
        check({name, "_cout"}, cout, e_cout);
        check({name, "_ovf"}, ovf, e_ovf);
        wait_drain({name, "_drain"});
    endtask

    task automatic back_to_back();
        logic [W-1:0] va[6] = '{16'h1234, 16'hFFFF, 16'h8000, 16'h00F0, 16'h7FFF, 16'h0F0F};
        logic [W-1:0] vb[6] = '{16'h4321, 16'h0001, 16'h8000, 16'h0F10, 16'h0001, 16'hF0F1};
        logic         vs[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        int n0;
        n0 = n_out;
        out_ready = 1'b1;
        fork
            begin : drv
                for (int i = 0; i < 6; i++) begin
                    bit acc;
                    int cnt;
                    acc = 1'b0;
                    cnt = 0;
                    set_op(va[i], vb[i], 1'b1, vs[i]);
                    in_valid = 1'b1;
                    while (!acc && cnt < 50) begin
                        @(negedge clk);
                        acc = in_ready;
                        step();
                        cnt++;
                    end
                    check("b2b_accept", acc, 1);
                end
                in_valid = 1'b0;
            end
            begin : rdy
                int cnt;
                cnt = 0;
                while (!out_valid && cnt < 50) begin
                    step();
                    cnt++;
                end
                out_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk);
                    check("stall_in_ready", in_ready, 0);
                    check("stall_out_valid", out_valid, 1);
                    step();
                end
                out_ready = 1'b1;
            end
        join
        wait_drain("b2b_drain");
        check("b2b_count", n_out - n0, 6);
    endtask

    task automatic reset_mid_flight();
        int n0;
        n0 = n_out;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_op(16'h0101 * W'(i + 1), 16'h0202, 1'b0, 1'b0);
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        step();
        rst_n = 1'b1;
        check("rst_mid_out_valid", out_valid, 0);
        check("rst_mid_sum", sum, 0);
        check("rst_mid_in_ready", in_ready, 1);
        repeat (10) step();
        check("rst_mid_no_results", n_out - n0, 0);
    endtask

    task automatic random_sweep(input int n_ops);
        for (int i = 0; i < n_ops; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            set_op(W'($urandom_range(0, 16'hFFFF)), W'($urandom_range(0, 16'hFFFF)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_drain("rand_drain");
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        set_op('0, '0, 1'b0, 1'b0);
        repeat (3) step();
        rst_n = 1'b1;

        check("reset_out_valid", out_valid, 0);
        check("reset_sum", sum, 0);
        check("reset_cout", cout, 0);
        check("reset_ovf", ovf, 0);
        check("reset_in_ready", in_ready, 1);

        single_op("add_seg_carry", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
        single_op("carry_all", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
`ifdef PIPELINED_RCA_SAT_EN
        single_op("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1);
        single_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1);
`else
        single_op("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        single_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
`endif
        single_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);

        back_to_back();
        reset_mid_flight();
        random_sweep(3000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
